hub75_capture: RTL and testbench

Receive-side counterpart of the HUB75 panel driver. Monitors a HUB75 bus (O_CLK, STB, OE, A–D, R1/G1/B1/R2/G2/B2), reconstructs each latched row pair, and writes the pixels into a frame store over a valid/ready pixel write stream. Serves as an on-chip loopback checker and capture path for the display driver.

---
 rtl/hub75_capture.sv | 134 +++++++++++++
 tb/tb_hub75_capture.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// hub75_capture: rebuilds latched HUB75 row pairs and streams them as pixel writes
// Ports: clk/rst (sync, active-high); i_O_CLK/i_STB/i_OE, i_A..i_D, i_R1..i_B2 HUB75 bus;
//        o_wr_valid/o_wr_addr/o_wr_data with i_wr_ready write stream;
//        o_row_done, o_len_err, o_overrun status pulses.
// Define HUB75_CAPTURE_SYNC_EN to put a 2-flop synchronizer in front of the input register.
module hub75_capture #(
    parameter int hpixel_p = 64,
    parameter int vpixel_p = 32,
    localparam int addr_width_p = $clog2(hpixel_p * vpixel_p)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_O_CLK,
    input  logic                    i_STB,
    input  logic                    i_OE,
    input  logic                    i_A,
    input  logic                    i_B,
    input  logic                    i_C,
    input  logic                    i_D,
    input  logic                    i_R1,
    input  logic                    i_G1,
    input  logic                    i_B1,
    input  logic                    i_R2,
    input  logic                    i_G2,
    input  logic                    i_B2,
    output logic                    o_wr_valid,
    output logic [addr_width_p-1:0] o_wr_addr,
    output logic [2:0]              o_wr_data,
    input  logic                    i_wr_ready,
    output logic                    o_row_done,
    output logic                    o_len_err,
    output logic                    o_overrun
);
    localparam int row_w = (vpixel_p / 2 > 1) ? $clog2(vpixel_p / 2) : 1;
    localparam int col_w = $clog2(hpixel_p);
    localparam int cnt_w = $clog2(hpixel_p + 1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(hpixel_p);
    localparam logic [col_w-1:0] last_col = col_w'(hpixel_p - 1);
    typedef enum logic [1:0] {IDLE, EMIT_TOP, EMIT_BOT} state_t;
    logic [12:0] pin, pin_s;
    logic [11:0] q;
    logic oe_unused;
    logic prev_clk, prev_stb;
    logic clk_rise, stb_rise;
    logic [5:0] sr [hpixel_p];
    logic [5:0] rowbuf [hpixel_p];
    logic [cnt_w-1:0] cnt;
    logic [col_w-1:0] col;
    logic [row_w-1:0] row, row_in;
    logic [addr_width_p-1:0] top_base, bot_base;
    state_t state;
    assign pin = {i_O_CLK, i_STB, i_OE, i_D, i_C, i_B, i_A, i_R1, i_G1, i_B1, i_R2, i_G2, i_B2};
`ifdef HUB75_CAPTURE_SYNC_EN
    logic [12:0] s1, s2;
    always_ff @(posedge clk) begin
        s1 <= pin;
        s2 <= s1;
    end
    assign pin_s = s2;
`else
    assign pin_s = pin;
`endif
    always_ff @(posedge clk) begin
        q <= {pin_s[12:11], pin_s[9:0]};
        oe_unused <= pin_s[10];
    end
    // Previous-value registers follow the incoming sample during reset, so a
    // line already high at release is not seen as a rising edge.
    always_ff @(posedge clk) begin
        prev_clk <= rst ? pin_s[12] : q[11];
        prev_stb <= rst ? pin_s[11] : q[10];
    end
    assign clk_rise = q[11] & ~prev_clk;
    assign stb_rise = q[10] & ~prev_stb;
    assign row_in = q[6 +: row_w];
    assign top_base = addr_width_p'(row_in) * addr_width_p'(hpixel_p);
    assign bot_base = (addr_width_p'(row) + addr_width_p'(vpixel_p / 2)) * addr_width_p'(hpixel_p);
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < hpixel_p; c++) begin
                sr[c] <= '0;
                rowbuf[c] <= '0;
            end
            cnt <= '0;
            col <= '0;
            row <= '0;
            state <= IDLE;
            o_wr_valid <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_row_done <= 1'b0;
            o_len_err <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_row_done <= 1'b0;
            o_len_err <= 1'b0;
            o_overrun <= 1'b0;
            if (clk_rise) begin
                for (int c = 0; c < hpixel_p - 1; c++) sr[c] <= sr[c+1];
                sr[hpixel_p-1] <= q[5:0];
            end
            // A latch clears the count; a coincident shift clock is the first of the next row.
            cnt <= stb_rise ? cnt_w'(clk_rise) : (clk_rise && cnt != full_cnt) ? cnt + 1'b1 : cnt;
            if (stb_rise && state == IDLE) begin
                rowbuf <= sr;
                row <= row_in;
                o_len_err <= cnt != full_cnt;
                state <= EMIT_TOP;
                col <= '0;
                o_wr_valid <= 1'b1;
                o_wr_addr <= top_base;
                o_wr_data <= sr[0][5:3];
            end else if (stb_rise) begin
                o_overrun <= 1'b1;
            end
            if (o_wr_valid && i_wr_ready) begin
                if (col != last_col) begin
                    col <= col + 1'b1;
                    o_wr_addr <= o_wr_addr + 1'b1;
                    o_wr_data <= state == EMIT_BOT ? rowbuf[col + 1'b1][2:0] : rowbuf[col + 1'b1][5:3];
                end else if (state == EMIT_TOP) begin
                    state <= EMIT_BOT;
                    col <= '0;
                    o_wr_addr <= bot_base;
                    o_wr_data <= rowbuf[0][2:0];
                end else begin
                    state <= IDLE;
                    o_wr_valid <= 1'b0;
                    o_row_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: directed scoreboard bench for hub75_capture
module tb_hub75_capture;
`ifdef HUB75_CAPTURE_SYNC_EN
    localparam int lat = 4;
`else
    localparam int lat = 2;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o_clk_p = 0, stb = 0, oe = 0, a = 0, b = 0, c = 0, d = 0;
    logic r1 = 0, g1 = 0, b1 = 0, r2 = 0, g2 = 0, b2 = 0;
    logic ready = 1'b1;
    logic wr_valid, row_done, len_err, overrun;
    logic [10:0] wr_addr;
    logic [2:0] wr_data;
    logic [5:0] m [64];
    logic [13:0] sb [$];
    int tests = 0, fails = 0, beat_cnt = 0, n_done = 0, n_len = 0, n_ovr = 0;
    logic prev_v = 0, prev_r = 0, prev_rst = 1;
    logic [10:0] prev_a = 0;
    logic [2:0] prev_d = 0;

    hub75_capture dut (
        .clk(clk), .rst(rst),
        .i_O_CLK(o_clk_p), .i_STB(stb), .i_OE(oe),
        .i_A(a), .i_B(b), .i_C(c), .i_D(d),
        .i_R1(r1), .i_G1(g1), .i_B1(b1), .i_R2(r2), .i_G2(g2), .i_B2(b2),
        .o_wr_valid(wr_valid), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .i_wr_ready(ready), .o_row_done(row_done), .o_len_err(len_err), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_v && !prev_r && !prev_rst)
                chk("hold", 32'({wr_valid, wr_addr, wr_data}), 32'({1'b1, prev_a, prev_d}));
            if (wr_valid && ready) begin
                chk("beat_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) chk("beat", 32'({wr_addr, wr_data}), 32'(sb.pop_front()));
                beat_cnt++;
            end
            if (row_done) begin
                n_done++;
                chk("done_valid", 32'(wr_valid), 0);
            end
            if (len_err) n_len++;
            if (overrun) n_ovr++;
        end
        prev_v = wr_valid;
        prev_r = ready;
        prev_a = wr_addr;
        prev_d = wr_data;
        prev_rst = rst;
    end

    task automatic model_latch(input int row, input bit accept);
        if (accept) begin
            for (int i = 0; i < 64; i++) sb.push_back({11'(row * 64 + i), m[i][5:3]});
            for (int i = 0; i < 64; i++) sb.push_back({11'((row + 16) * 64 + i), m[i][2:0]});
        end
    endtask

    task automatic pulse(input logic [5:0] px, input bit with_stb, input int row);
        {r1, g1, b1, r2, g2, b2} = px;
        o_clk_p = 1'b1;
        if (with_stb) begin
            {d, c, b, a} = 4'(row);
            stb = 1'b1;
            model_latch(row, 1);
        end
        for (int i = 0; i < 63; i++) m[i] = m[i+1];
        m[63] = px;
        @(posedge clk) #1;
        o_clk_p = 1'b0;
        stb = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic shift_rand(input int n);
        for (int i = 0; i < n; i++) pulse(6'($urandom), 0, 0);
    endtask

    task automatic strobe(input int row, input bit accept);
        {d, c, b, a} = 4'(row);
        stb = 1'b1;
        model_latch(row, accept);
        @(posedge clk) #1;
        stb = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 1000 && n_done < target; i++) @(posedge clk);
        #1;
        chk("row_done_count", 32'(n_done), 32'(target));
        chk("sb_drained", 32'(sb.size()), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m[i] = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            #1;
            {o_clk_p, stb, oe, d, c, b, a, r1, g1, b1, r2, g2, b2} = 13'($urandom);
            @(negedge clk);
            chk("reset_outputs", 32'({wr_valid, wr_addr, wr_data, row_done, len_err, overrun}), 0);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("no_beat_after_release", 32'(wr_valid), 0);
        end
        @(posedge clk) #1;
        {o_clk_p, stb, oe, d, c, b, a, r1, g1, b1, r2, g2, b2} = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_valid", 32'(wr_valid), 0);

        // full row with first/last pixel markers, latched to row pair 5
        pulse(6'b100000, 0, 0);
        for (int i = 0; i < 62; i++) pulse(6'b000000, 0, 0);
        pulse(6'b000010, 0, 0);
        {d, c, b, a} = 4'd5;
        stb = 1'b1;
        model_latch(5, 1);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            chk("latch_latency", 32'(wr_valid), 32'(k == lat + 1));
        end
        chk("first_addr", 32'(wr_addr), 320);
        chk("first_data", 32'(wr_data), 32'(3'b100));
        @(posedge clk) #1;
        stb = 1'b0;
        wait_done(1);
        chk("last_addr", 32'(prev_a), 1407);
        chk("last_data", 32'(prev_d), 32'(3'b010));
        chk("len_err_none", 32'(n_len), 0);

        // backpressure on beat 3
        shift_rand(64);
        beat_cnt = 0;
        strobe(5, 1);
        for (int i = 0; i < 200 && beat_cnt < 3; i++) @(posedge clk);
        #1 ready = 1'b0;
        @(negedge clk);
        chk("stall_addr", 32'(wr_addr), 323);
        repeat (10) @(posedge clk);
        #1 ready = 1'b1;
        wait_done(2);
        chk("bp_beats", 32'(beat_cnt), 128);

        // overrun: second latch 20 cycles after the first
        shift_rand(64);
        strobe(9, 1);
        repeat (18) @(posedge clk);
        #1;
        strobe(9, 0);
        wait_done(3);
        repeat (30) @(posedge clk);
        #1;
        chk("overrun_count", 32'(n_ovr), 1);
        chk("overrun_rows", 32'(n_done), 3);

        // short row: 63 clocks
        shift_rand(63);
        strobe(2, 1);
        wait_done(4);
        chk("len_err_count", 32'(n_len), 1);

        // simultaneous O_CLK/STB edges, then a row whose count starts at 1
        shift_rand(64);
        pulse(6'($urandom), 1, 15);
        wait_done(5);
        shift_rand(63);
        beat_cnt = 0;
        strobe(7, 1);
        for (int i = 0; i < 300 && beat_cnt < 50; i++) @(posedge clk);
        #1;
        rst = 1'b1;
        ready = 1'b0;
        @(posedge clk) #1;
        rst = 1'b0;
        ready = 1'b1;
        sb.delete();
        for (int i = 0; i < 64; i++) m[i] = '0;
        @(negedge clk);
        chk("valid_after_reset", 32'(wr_valid), 0);
        repeat (150) @(posedge clk);
        #1;
        chk("beats_after_reset", 32'(beat_cnt), 50);
        chk("rows_after_reset", 32'(n_done), 5);
        chk("len_err_final", 32'(n_len), 1);
        chk("overrun_final", 32'(n_ovr), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
